// File: rtl/mmu_param.sv
// Shared allocator constants: size classes, widths and FDT search FSM encoding.
package mmu_param;

  localparam logic [1:0] REQ_512 = 2'd0;
  localparam logic [1:0] REQ_1K  = 2'd1;
  localparam logic [1:0] REQ_2K  = 2'd2;
  localparam logic [1:0] REQ_4K  = 2'd3;

  localparam int unsigned REQ_ID_WIDTH    = 8;
  localparam int unsigned FDT_INDEX_WIDTH = 6;
  localparam int unsigned FDT_BIT_WIDTH   = 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SEARCH = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_FAIL   = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;

endpackage

// File: rtl/fdt_search_if.sv
// Request, search-issue, failure and FDT-update signals of the FDT front end.
interface fdt_search_if #(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned ID_W  = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [ID_W-1:0]   req_id;
  logic [1:0]        req_size;
  logic [1:0]        req_origin_size;

  logic              alloc_valid_fdt_out;
  logic [ID_W-1:0]   alloc_id_fdt_out;
  logic [IDX_W-1:0]  alloc_pos_fdt_out;
  logic [1:0]        alloc_size_fdt_out;
  logic [1:0]        alloc_origin_size_fdt_out;

  logic              alloc_fail_valid;
  logic [ID_W-1:0]   alloc_fail_id;

  logic              fdt_update_valid;
  logic [IDX_W-1:0]  fdt_update_idx;
  logic [3:0]        fdt_update_bit_sequence;

  logic              wait_timeout_err;

  // Environment side: requester and and-tree
  modport master (
    output req_valid, req_id, req_size, req_origin_size,
    output fdt_update_valid, fdt_update_idx, fdt_update_bit_sequence,
    input  req_ready,
    input  alloc_valid_fdt_out, alloc_id_fdt_out, alloc_pos_fdt_out,
    input  alloc_size_fdt_out, alloc_origin_size_fdt_out,
    input  alloc_fail_valid, alloc_fail_id, wait_timeout_err
  );

  // FDT search block side
  modport slave (
    input  req_valid, req_id, req_size, req_origin_size,
    input  fdt_update_valid, fdt_update_idx, fdt_update_bit_sequence,
    output req_ready,
    output alloc_valid_fdt_out, alloc_id_fdt_out, alloc_pos_fdt_out,
    output alloc_size_fdt_out, alloc_origin_size_fdt_out,
    output alloc_fail_valid, alloc_fail_id, wait_timeout_err
  );
endinterface

// File: rtl/fdt_priority_enc.sv
// LSB-first first-zero finder over the per-row "full" vector.
module fdt_priority_enc #(
  parameter int unsigned IDX_W = 6
) (
  input  logic [(1<<IDX_W)-1:0] i_vec,
  output logic                  o_found,
  output logic [IDX_W-1:0]      o_idx
);
  localparam int unsigned DEPTH = 1 << IDX_W;

  // Scan high to low so the lowest zero is the last one written
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!i_vec[i]) begin
        o_found = 1'b1;
        o_idx   = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/fdt_search.sv
// FDT front end: picks the lowest non-full row per request and waits for its update.
module fdt_search
  import mmu_param::*;
#(
  parameter int unsigned FDT_INDEX_WIDTH = 6,
  parameter int unsigned REQ_ID_WIDTH    = 8,
  parameter int unsigned WAIT_TIMEOUT    = 16
) (
  input logic         clk,
  input logic         rst,
  fdt_search_if.slave bus
);
  localparam int unsigned FDT_DEPTH = 1 << FDT_INDEX_WIDTH;
  localparam int unsigned CNT_W     = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;

  logic [FDT_BIT_WIDTH-1:0]   r_fdt [FDT_DEPTH];
  logic [2:0]                 r_state;
  logic [2:0]                 w_next;
  logic [REQ_ID_WIDTH-1:0]    r_id;
  logic [1:0]                 r_size;
  logic [1:0]                 r_origin;
  logic [CNT_W-1:0]           r_cnt;
  logic [FDT_DEPTH-1:0]       w_vec;
  logic                       w_found;
  logic [FDT_INDEX_WIDTH-1:0] w_idx;
  logic                       w_timeout;

  logic                       r_req_ready;
  logic                       r_alloc_valid;
  logic [REQ_ID_WIDTH-1:0]    r_alloc_id;
  logic [FDT_INDEX_WIDTH-1:0] r_alloc_pos;
  logic [1:0]                 r_alloc_size;
  logic [1:0]                 r_alloc_origin;
  logic                       r_fail_valid;
  logic [REQ_ID_WIDTH-1:0]    r_fail_id;

  // Table write: whole-row overwrite from any and-tree update, in any state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(FDT_DEPTH); i++) r_fdt[i] <= '0;
    end else if (bus.fdt_update_valid) begin
      r_fdt[bus.fdt_update_idx] <= bus.fdt_update_bit_sequence;
    end
  end

  // Search vector for the latched size, with same-cycle update bypass
  always_comb begin
    w_vec = '0;
    for (int i = 0; i < int'(FDT_DEPTH); i++) begin
      if (bus.fdt_update_valid && bus.fdt_update_idx == FDT_INDEX_WIDTH'(i))
        w_vec[i] = bus.fdt_update_bit_sequence[r_size];
      else
        w_vec[i] = r_fdt[i][r_size];
    end
  end

  fdt_priority_enc #(.IDX_W(FDT_INDEX_WIDTH)) u_enc (
    .i_vec   (w_vec),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  // Timeout fires on the last wait cycle unless an update closes the wait first
  assign w_timeout = (r_state == S_WAIT) && !bus.fdt_update_valid &&
                     (r_cnt == CNT_W'(WAIT_TIMEOUT - 1));

  // Next-state decode
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:   w_next = bus.req_valid ? S_SEARCH : S_IDLE;
      S_SEARCH: w_next = w_found ? S_ISSUE : S_FAIL;
      S_ISSUE:  w_next = S_WAIT;
      S_FAIL:   w_next = S_IDLE;
      S_WAIT:   w_next = (bus.fdt_update_valid || w_timeout) ? S_IDLE : S_WAIT;
      default:  w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Request latch and wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id     <= '0;
      r_size   <= '0;
      r_origin <= '0;
      r_cnt    <= '0;
    end else begin
      if (r_state == S_IDLE && bus.req_valid) begin
        r_id     <= bus.req_id;
        r_size   <= bus.req_size;
        r_origin <= bus.req_origin_size;
      end
      if (r_state == S_ISSUE)     r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Registered outputs decoded from the upcoming state; fields zero when not valid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_ready    <= 1'b1;
      r_alloc_valid  <= 1'b0;
      r_alloc_id     <= '0;
      r_alloc_pos    <= '0;
      r_alloc_size   <= '0;
      r_alloc_origin <= '0;
      r_fail_valid   <= 1'b0;
      r_fail_id      <= '0;
    end else begin
      r_req_ready    <= (w_next == S_IDLE);
      r_alloc_valid  <= (w_next == S_ISSUE);
      r_alloc_id     <= (w_next == S_ISSUE) ? r_id     : '0;
      r_alloc_pos    <= (w_next == S_ISSUE) ? w_idx    : '0;
      r_alloc_size   <= (w_next == S_ISSUE) ? r_size   : '0;
      r_alloc_origin <= (w_next == S_ISSUE) ? r_origin : '0;
      r_fail_valid   <= (w_next == S_FAIL);
      r_fail_id      <= (w_next == S_FAIL)  ? r_id     : '0;
    end
  end

  assign bus.req_ready                 = r_req_ready;
  assign bus.alloc_valid_fdt_out       = r_alloc_valid;
  assign bus.alloc_id_fdt_out          = r_alloc_id;
  assign bus.alloc_pos_fdt_out         = r_alloc_pos;
  assign bus.alloc_size_fdt_out        = r_alloc_size;
  assign bus.alloc_origin_size_fdt_out = r_alloc_origin;
  assign bus.alloc_fail_valid          = r_fail_valid;
  assign bus.alloc_fail_id             = r_fail_id;
  assign bus.wait_timeout_err          = w_timeout;
endmodule

// File: tb/tb_fdt_search.sv
// Directed bench for fdt_search: issue, update handshake, fail, timeout, bypass, reset.
module tb_fdt_search;
  import mmu_param::*;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  fdt_search_if #(.IDX_W(FDT_INDEX_WIDTH), .ID_W(REQ_ID_WIDTH)) bus ();

  fdt_search #(
    .FDT_INDEX_WIDTH (FDT_INDEX_WIDTH),
    .REQ_ID_WIDTH    (REQ_ID_WIDTH),
    .WAIT_TIMEOUT    (16)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs settle and inputs change 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request in the current (IDLE) cycle; returns in the SEARCH cycle
  task automatic send_req(input logic [7:0] id, input logic [1:0] size, input logic [1:0] orig);
    bus.req_valid       = 1'b1;
    bus.req_id          = id;
    bus.req_size        = size;
    bus.req_origin_size = orig;
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Drive one update for the current cycle
  task automatic upd(input logic [5:0] idx, input logic [3:0] seq);
    bus.fdt_update_valid        = 1'b1;
    bus.fdt_update_idx          = idx;
    bus.fdt_update_bit_sequence = seq;
    tick();
    bus.fdt_update_valid = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_id = '0;
    bus.req_size = '0;
    bus.req_origin_size = '0;
    bus.fdt_update_valid = 1'b0;
    bus.fdt_update_idx = '0;
    bus.fdt_update_bit_sequence = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset values
    chk("rst_ready",    32'(bus.req_ready), 32'd1);
    chk("rst_avalid",   32'(bus.alloc_valid_fdt_out), 32'd0);
    chk("rst_fvalid",   32'(bus.alloc_fail_valid), 32'd0);
    chk("rst_pos",      32'(bus.alloc_pos_fdt_out), 32'd0);
    chk("rst_fail_id",  32'(bus.alloc_fail_id), 32'd0);
    chk("rst_timeout",  32'(bus.wait_timeout_err), 32'd0);

    // First request: 1K, id 5 -> row 0 two cycles after handshake
    send_req(8'd5, REQ_1K, REQ_2K);
    chk("t1_ready_search",  32'(bus.req_ready), 32'd0);
    chk("t1_avalid_search", 32'(bus.alloc_valid_fdt_out), 32'd0);
    tick();
    chk("t1_avalid", 32'(bus.alloc_valid_fdt_out), 32'd1);
    chk("t1_pos",    32'(bus.alloc_pos_fdt_out), 32'd0);
    chk("t1_size",   32'(bus.alloc_size_fdt_out), 32'd1);
    chk("t1_id",     32'(bus.alloc_id_fdt_out), 32'd5);
    chk("t1_orig",   32'(bus.alloc_origin_size_fdt_out), 32'd2);
    chk("t1_ready_issue", 32'(bus.req_ready), 32'd0);
    tick();
    chk("t1_avalid_once", 32'(bus.alloc_valid_fdt_out), 32'd0);
    chk("t1_id_zero",     32'(bus.alloc_id_fdt_out), 32'd0);
    chk("t1_ready_wait0", 32'(bus.req_ready), 32'd0);
    tick();
    chk("t1_ready_wait1", 32'(bus.req_ready), 32'd0);

    // Update row 0 (1K full) ends the wait
    upd(6'd0, 4'b0010);
    chk("t2_ready_after_upd", 32'(bus.req_ready), 32'd1);
    send_req(8'd6, REQ_1K, REQ_1K);
    tick();
    chk("t2_1k_avalid", 32'(bus.alloc_valid_fdt_out), 32'd1);
    chk("t2_1k_pos",    32'(bus.alloc_pos_fdt_out), 32'd1);
    tick();
    upd(6'd1, 4'b0000);
    send_req(8'd7, REQ_512, REQ_512);
    tick();
    chk("t2_512_pos", 32'(bus.alloc_pos_fdt_out), 32'd0);
    chk("t2_512_id",  32'(bus.alloc_id_fdt_out), 32'd7);
    tick();
    upd(6'd0, 4'b0010);

    // Mark 4K full on every row, then a 4K request must fail
    for (int r = 0; r < 64; r++) upd(6'(r), 4'b1000);
    send_req(8'd9, REQ_4K, REQ_4K);
    tick();
    chk("t3_fvalid",     32'(bus.alloc_fail_valid), 32'd1);
    chk("t3_fail_id",    32'(bus.alloc_fail_id), 32'd9);
    chk("t3_no_avalid",  32'(bus.alloc_valid_fdt_out), 32'd0);
    tick();
    chk("t3_ready_k3",   32'(bus.req_ready), 32'd1);
    chk("t3_fvalid_off", 32'(bus.alloc_fail_valid), 32'd0);
    chk("t3_fid_zero",   32'(bus.alloc_fail_id), 32'd0);
    send_req(8'd10, REQ_512, REQ_512);
    tick();
    chk("t3_k3_avalid", 32'(bus.alloc_valid_fdt_out), 32'd1);
    chk("t3_k3_pos",    32'(bus.alloc_pos_fdt_out), 32'd0);

    // No update: timeout pulse 16 cycles after ISSUE
    for (int j = 1; j <= 15; j++) begin
      tick();
      chk("t4_no_early_timeout", 32'(bus.wait_timeout_err), 32'd0);
    end
    tick();
    chk("t4_timeout",        32'(bus.wait_timeout_err), 32'd1);
    chk("t4_ready_at_pulse", 32'(bus.req_ready), 32'd0);
    tick();
    chk("t4_timeout_off",    32'(bus.wait_timeout_err), 32'd0);
    chk("t4_ready_after",    32'(bus.req_ready), 32'd1);

    // Bypass: row 0 becomes 512-full in the SEARCH cycle
    send_req(8'd11, REQ_512, REQ_512);
    upd(6'd0, 4'b1001);
    chk("t5_avalid", 32'(bus.alloc_valid_fdt_out), 32'd1);
    chk("t5_pos",    32'(bus.alloc_pos_fdt_out), 32'd1);
    chk("t5_id",     32'(bus.alloc_id_fdt_out), 32'd11);
    // Update during ISSUE does not end the wait
    upd(6'd2, 4'b1000);
    chk("t5_wait_after_issue_upd", 32'(bus.req_ready), 32'd0);
    tick();
    chk("t5_still_waiting", 32'(bus.req_ready), 32'd0);

    // Reset during WAIT clears state and table
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_ready",   32'(bus.req_ready), 32'd1);
    chk("t6_avalid",  32'(bus.alloc_valid_fdt_out), 32'd0);
    chk("t6_fvalid",  32'(bus.alloc_fail_valid), 32'd0);
    chk("t6_timeout", 32'(bus.wait_timeout_err), 32'd0);
    send_req(8'd12, REQ_4K, REQ_4K);
    tick();
    chk("t6_4k_avalid", 32'(bus.alloc_valid_fdt_out), 32'd1);
    chk("t6_4k_pos",    32'(bus.alloc_pos_fdt_out), 32'd0);
    chk("t6_4k_nofail", 32'(bus.alloc_fail_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/fdt_search.md
Name: fdt_search

Overview:
- Free-descriptor-table (FDT) front end of the allocator; it issues the search requests that the and-tree consumes and absorbs the and-tree's FDT update stream.
- Holds one "row full" bit per AT-tree row per size class.
- For each accepted alloc request it picks the lowest non-full row for the requested size and sends it downstream.
- It then blocks further requests until the and-tree reports the row's new status, so no request ever targets stale state.

Parameters:
- FDT_INDEX_WIDTH, 6, row index width; FDT_DEPTH = 2**FDT_INDEX_WIDTH rows.
- REQ_ID_WIDTH, 8, request id width.
- WAIT_TIMEOUT, 16, cycles to wait for the FDT update before flagging an error; must be >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  alloc request valid.
- req_ready  out  1  block can accept a request.
- req_id  in  REQ_ID_WIDTH  request id.
- req_size  in  2  aligned size class (REQ_512/1K/2K/4K = 0/1/2/3).
- req_origin_size  in  2  original size class, passed through.
- alloc_valid_fdt_out  out  1  search request to and-tree.
- alloc_id_fdt_out  out  REQ_ID_WIDTH  id.
- alloc_pos_fdt_out  out  FDT_INDEX_WIDTH  selected AT-tree row.
- alloc_size_fdt_out  out  2  aligned size.
- alloc_origin_size_fdt_out  out  2  original size.
- alloc_fail_valid  out  1  no row free for the size.
- alloc_fail_id  out  REQ_ID_WIDTH  id of the failed request.
- fdt_update_valid  in  1  update from and-tree.
- fdt_update_idx  in  FDT_INDEX_WIDTH  row to update.
- fdt_update_bit_sequence  in  4  full bits {4K,2K,1K,512} for that row.
- wait_timeout_err  out  1  one-cycle pulse when the update wait times out.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset effect: state=IDLE; all FDT bits 0 (every row has space); every output 0 except req_ready, which is 1 in the first cycle after reset.
- Storage: fdt[row][size], FDT_DEPTH x 4 flops.
- Update write: any cycle, any state, with fdt_update_valid=1: fdt[fdt_update_idx] <= fdt_update_bit_sequence. A whole-row overwrite, not a merge. Unsolicited updates from frees are applied the same way.
- Search vector: bit i = fdt[i][size_q], with a same-cycle bypass. If fdt_update_valid and fdt_update_idx==i, the incoming bit is used instead.
- Search result: LSB-first first-zero over the vector; found=0 when all ones.
- FSM:
  - IDLE: req_ready=1. If req_valid, latch id/size/origin_size and go to SEARCH.
  - SEARCH: if found, register pos and go to ISSUE; else go to FAIL.
  - ISSUE: alloc_valid_fdt_out=1 for exactly one cycle, with the latched fields and pos. Clear the wait counter; go to WAIT.
  - FAIL: alloc_fail_valid=1 and alloc_fail_id=latched id for one cycle; go to IDLE.
  - WAIT: counter increments each cycle.
    - If fdt_update_valid=1, go to IDLE, whatever the idx; the update has already been applied by the write rule.
    - Else if counter==WAIT_TIMEOUT-1, pulse wait_timeout_err and go to IDLE.
- Latency: handshake in cycle k; SEARCH in k+1; alloc_valid_fdt_out (or alloc_fail_valid) in k+2. The next request can be accepted no earlier than the cycle after the update arrives. A failed request can be followed by an accept at k+3.
- req_ready: 1 only in IDLE; no combinational path from req_valid.
- Output values: all alloc_*_fdt_out and alloc_fail_id fields read 0 whenever their valid is 0.
- Update in ISSUE: applied to the table; the FSM still goes to WAIT. That update does not end the wait.
- Reset in mid-operation (any state): next state IDLE, table cleared, pending request dropped, no pulse outputs.

Decomposition:
- Package mmu_param:
  - size-class constants REQ_512/REQ_1K/REQ_2K/REQ_4K;
  - REQ_ID_WIDTH, FDT_INDEX_WIDTH, FDT_BIT_WIDTH=4;
  - FSM state encoding.
- Sub-module fdt_priority_enc: purely combinational LSB-first first-zero finder. Inputs are the FDT_DEPTH-bit vector; outputs are found and index.

Test Plan:
- Reset, then req id=5 size=1K accepted in cycle k -> alloc_valid_fdt_out in k+2, pos=0, size=1, id=5; req_ready=0 until an update arrives.
- In WAIT, update idx=0 seq=4'b0010 -> IDLE next cycle. Then a 1K req -> pos=1, and a 512 req -> pos=0.
- Updates set bit 4K on all 64 rows; req id=9 size=4K -> alloc_fail_valid=1 with id=9 at k+2, no alloc_valid; a new accept at k+3.
- Issue with no update -> wait_timeout_err pulses exactly 16 cycles after the ISSUE cycle; req_ready=1 the following cycle.
- Row 0 full for 512 applied via update in the same cycle as SEARCH for size=512 -> bypass gives pos=1.
- rst=1 during WAIT after filling rows -> next cycle IDLE, outputs 0; a later 4K req returns pos=0.
